// File: rtl/alu_issue_stage.sv
// RV32I decode/issue slot feeding the ALU: one registered op, 1-cycle latency.
// Holds its outputs while out_ready_i is low; flush_i kills the slot and any same-cycle input.
module alu_issue_stage #(
  parameter int          CNT_W    = 16,
  parameter logic [3:0]  NOP_CTRL = 4'b0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      rs1_data_i,
  input  logic [31:0]      rs2_data_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [3:0]       alu_ctrl_o,
  output logic [31:0]      src0_o,
  output logic [31:0]      src1_o,
  output logic [4:0]       rd_o,
  output logic             reg_write_o,
  output logic             is_branch_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] issue_count_o
);

  localparam logic [3:0] CTRL_PASS = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0011;
  localparam logic [3:0] CTRL_SLT  = 4'b0100;
  localparam logic [3:0] CTRL_XOR  = 4'b0101;
  localparam logic [3:0] CTRL_SLL  = 4'b0110;
  localparam logic [3:0] CTRL_AND  = 4'b0111;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_fld;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  assign opcode = instr_i[6:0];
  assign rd_fld = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u  = {instr_i[31:12], 12'b0};

  logic [3:0]  dec_ctrl;
  logic [31:0] dec_src0;
  logic [31:0] dec_src1;
  logic        dec_rw;
  logic        dec_br;
  logic        dec_legal;

  always_comb begin
    dec_ctrl  = NOP_CTRL;
    dec_src0  = 32'd0;
    dec_src1  = 32'd0;
    dec_rw    = 1'b0;
    dec_br    = 1'b0;
    dec_legal = 1'b0;
    unique case (opcode)
      OPC_R: begin
        dec_src0 = rs1_data_i;
        dec_src1 = rs2_data_i;
        dec_rw   = 1'b1;
        unique case (funct3)
          3'b000: begin
            if (funct7 == F7_ZERO) begin
              dec_ctrl  = CTRL_ADD;
              dec_legal = 1'b1;
            end else if (funct7 == F7_ALT) begin
              dec_ctrl  = CTRL_SUB;
              dec_legal = 1'b1;
            end
          end
          3'b111: begin dec_ctrl = CTRL_AND; dec_legal = (funct7 == F7_ZERO); end
          3'b110: begin dec_ctrl = CTRL_OR;  dec_legal = (funct7 == F7_ZERO); end
          3'b100: begin dec_ctrl = CTRL_XOR; dec_legal = (funct7 == F7_ZERO); end
          3'b010: begin dec_ctrl = CTRL_SLT; dec_legal = (funct7 == F7_ZERO); end
          3'b001: begin dec_ctrl = CTRL_SLL; dec_legal = (funct7 == F7_ZERO); end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_I: begin
        dec_src0 = rs1_data_i;
        dec_src1 = imm_i;
        dec_rw   = 1'b1;
        unique case (funct3)
          3'b000: begin dec_ctrl = CTRL_ADD; dec_legal = 1'b1; end
          3'b111: begin dec_ctrl = CTRL_AND; dec_legal = 1'b1; end
          3'b110: begin dec_ctrl = CTRL_OR;  dec_legal = 1'b1; end
          3'b100: begin dec_ctrl = CTRL_XOR; dec_legal = 1'b1; end
          3'b010: begin dec_ctrl = CTRL_SLT; dec_legal = 1'b1; end
          3'b001: begin
            // Shift amount only; the upper immediate bits must be zero.
            dec_ctrl  = CTRL_SLL;
            dec_src1  = {27'b0, instr_i[24:20]};
            dec_legal = (funct7 == F7_ZERO);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_ctrl  = CTRL_ADD;
        dec_src0  = rs1_data_i;
        dec_src1  = imm_i;
        dec_rw    = 1'b1;
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      OPC_STORE: begin
        dec_ctrl  = CTRL_ADD;
        dec_src0  = rs1_data_i;
        dec_src1  = imm_s;
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_BRANCH: begin
        dec_ctrl  = CTRL_SUB;
        dec_src0  = rs1_data_i;
        dec_src1  = rs2_data_i;
        dec_br    = 1'b1;
        dec_legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      end
      OPC_LUI: begin
        dec_ctrl  = CTRL_PASS;
        dec_src1  = imm_u;
        dec_rw    = 1'b1;
        dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_ctrl  = CTRL_ADD;
        dec_src0  = pc_i;
        dec_src1  = imm_u;
        dec_rw    = 1'b1;
        dec_legal = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // Link value pc+4 is computed by the ALU.
        dec_ctrl  = CTRL_ADD;
        dec_src0  = pc_i;
        dec_src1  = 32'd4;
        dec_rw    = 1'b1;
        dec_legal = (opcode == OPC_JAL) || (funct3 == 3'b000);
      end
      default: dec_legal = 1'b0;
    endcase

    if (!dec_legal) begin
      dec_ctrl = NOP_CTRL;
      dec_src0 = 32'd0;
      dec_src1 = 32'd0;
      dec_rw   = 1'b0;
      dec_br   = 1'b0;
    end
    if (rd_fld == 5'd0) begin
      dec_rw = 1'b0;
    end
  end

  logic accept;

  assign in_ready_o = !out_valid_o || out_ready_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_valid_o   <= 1'b0;
      alu_ctrl_o    <= NOP_CTRL;
      src0_o        <= 32'd0;
      src1_o        <= 32'd0;
      rd_o          <= 5'd0;
      reg_write_o   <= 1'b0;
      is_branch_o   <= 1'b0;
      illegal_o     <= 1'b0;
      issue_count_o <= '0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      alu_ctrl_o  <= dec_ctrl;
      src0_o      <= dec_src0;
      src1_o      <= dec_src1;
      rd_o        <= rd_fld;
      reg_write_o <= dec_rw;
      is_branch_o <= dec_br;
      if (dec_legal) begin
        issue_count_o <= issue_count_o + CNT_W'(1);
      end else begin
        illegal_o <= 1'b1;
      end
    end else if (flush_i || out_ready_i) begin
      // Slot drained or killed with nothing to refill it.
      out_valid_o <= 1'b0;
      alu_ctrl_o  <= NOP_CTRL;
      reg_write_o <= 1'b0;
      is_branch_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table plus scoreboard queue, with hand sequences for stall/flush/reset.
module tb_alu_issue_stage;

  localparam int CNT_W = 16;
  localparam logic [31:0] RS1V = 32'h8000_0010;
  localparam logic [31:0] RS2V = 32'h0000_0FF0;
  localparam logic [31:0] PCV  = 32'h0000_4000;
  localparam int NVEC = 26;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [31:0]      instr_i = 32'd0;
  logic [31:0]      pc_i = 32'd0;
  logic [31:0]      rs1_data_i = 32'd0;
  logic [31:0]      rs2_data_i = 32'd0;
  logic             flush_i = 1'b0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic [3:0]       alu_ctrl_o;
  logic [31:0]      src0_o;
  logic [31:0]      src1_o;
  logic [4:0]       rd_o;
  logic             reg_write_o;
  logic             is_branch_o;
  logic             illegal_o;
  logic [CNT_W-1:0] issue_count_o;

  alu_issue_stage #(.CNT_W(CNT_W), .NOP_CTRL(4'b0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_ctrl_o(alu_ctrl_o), .src0_o(src0_o), .src1_o(src1_o), .rd_o(rd_o),
    .reg_write_o(reg_write_o), .is_branch_o(is_branch_o), .illegal_o(illegal_o),
    .issue_count_o(issue_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  ctrl;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t             v;
    logic [CNT_W-1:0] cnt;
    logic             ill_st;
  } exp_t;

  vec_t             tbl [NVEC];
  exp_t             sb [$];
  int               n_chk = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic             exp_ill = 1'b0;
  bit               rand_bp = 1'b0;

  function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] ctrl,
                              input logic [31:0] s0, input logic [31:0] s1, input logic [4:0] rd,
                              input logic rw, input logic br, input logic ill);
    vec_t v;
    v.instr = instr; v.ctrl = ctrl; v.src0 = s0; v.src1 = s1;
    v.rd = rd; v.rw = rw; v.br = br; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard pop at the sampling edge whenever the ALU side takes an op.
  task automatic sample();
    exp_t e;
    if (!rst_i || !(out_valid_o && out_ready_i)) return;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_output: got ctrl %h, expected no op", alu_ctrl_o);
      return;
    end
    e = sb.pop_front();
    chk("ctrl", {28'd0, alu_ctrl_o}, {28'd0, e.v.ctrl});
    chk("src0", src0_o, e.v.src0);
    chk("src1", src1_o, e.v.src1);
    chk("rd", {27'd0, rd_o}, {27'd0, e.v.rd});
    chk("reg_write", {31'd0, reg_write_o}, {31'd0, e.v.rw});
    chk("is_branch", {31'd0, is_branch_o}, {31'd0, e.v.br});
    chk("illegal", {31'd0, illegal_o}, {31'd0, e.ill_st});
    chk("count", {16'd0, issue_count_o}, {16'd0, e.cnt});
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    sample();
  endtask

  task automatic to_pos();
    @(posedge clk_i);
    #1;
  endtask

  task automatic tick();
    at_neg();
    to_pos();
  endtask

  vec_t cur;

  task automatic apply(input vec_t v, input logic [31:0] rs1, input logic [31:0] rs2);
    cur        = v;
    in_valid_i = 1'b1;
    instr_i    = v.instr;
    rs1_data_i = rs1;
    rs2_data_i = rs2;
    pc_i       = PCV;
    if (rand_bp) out_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    in_valid_i = 1'b0;
    instr_i    = 32'd0;
  endtask

  task automatic wait_accept(output int cycles);
    exp_t e;
    bit   acc;
    cycles = 0;
    for (int k = 0; k < 100; k++) begin
      at_neg();
      acc = in_ready_o && in_valid_i && !flush_i;
      cycles++;
      if (acc) begin
        if (!cur.ill) exp_cnt = exp_cnt + 1'b1;
        exp_ill = exp_ill | cur.ill;
        e.v = cur; e.cnt = exp_cnt; e.ill_st = exp_ill;
        sb.push_back(e);
      end
      to_pos();
      if (acc) return;
      if (rand_bp) out_ready_i = 1'($urandom_range(0, 1));
    end
    n_chk++;
    n_err++;
    $display("FAIL accept_timeout: got no accept in %0d cycles, expected accept", cycles);
  endtask

  task automatic reset_dut();
    rst_i = 1'b0;
    idle();
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b1;
    sb.delete();
    exp_cnt = '0;
    exp_ill = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    int   tot;
    vec_t v_add, v_sub, v_and, v_sra, v_lui;

    tbl[0]  = mk(32'h80008293, 4'b0010, RS1V, 32'hFFFFF800, 5'd5,  1, 0, 0);
    tbl[1]  = mk(32'h01F09313, 4'b0110, RS1V, 32'd31,       5'd6,  1, 0, 0);
    tbl[2]  = mk(32'h0FF0F393, 4'b0111, RS1V, 32'h000000FF, 5'd7,  1, 0, 0);
    tbl[3]  = mk(32'h7FF0E413, 4'b0001, RS1V, 32'h000007FF, 5'd8,  1, 0, 0);
    tbl[4]  = mk(32'hFFF0C493, 4'b0101, RS1V, 32'hFFFFFFFF, 5'd9,  1, 0, 0);
    tbl[5]  = mk(32'hFFB0A513, 4'b0100, RS1V, 32'hFFFFFFFB, 5'd10, 1, 0, 0);
    tbl[6]  = mk(32'h00108013, 4'b0010, RS1V, 32'd1,        5'd0,  0, 0, 0);
    tbl[7]  = mk(32'h12308593, 4'b0010, RS1V, 32'h00000123, 5'd11, 1, 0, 0);
    tbl[8]  = mk(32'h0020E633, 4'b0001, RS1V, RS2V,         5'd12, 1, 0, 0);
    tbl[9]  = mk(32'h0020C6B3, 4'b0101, RS1V, RS2V,         5'd13, 1, 0, 0);
    tbl[10] = mk(32'h0020A733, 4'b0100, RS1V, RS2V,         5'd14, 1, 0, 0);
    tbl[11] = mk(32'h002097B3, 4'b0110, RS1V, RS2V,         5'd15, 1, 0, 0);
    tbl[12] = mk(32'hFFC0A803, 4'b0010, RS1V, 32'hFFFFFFFC, 5'd16, 1, 0, 0);
    tbl[13] = mk(32'h0020A423, 4'b0010, RS1V, 32'd8,        5'd8,  0, 0, 0);
    tbl[14] = mk(32'hFE20AA23, 4'b0010, RS1V, 32'hFFFFFFF4, 5'd20, 0, 0, 0);
    tbl[15] = mk(32'h00208063, 4'b0011, RS1V, RS2V,         5'd0,  0, 1, 0);
    tbl[16] = mk(32'h00209463, 4'b0011, RS1V, RS2V,         5'd8,  0, 1, 0);
    tbl[17] = mk(32'h0020C063, 4'b0000, 32'd0, 32'd0,       5'd0,  0, 0, 1);
    tbl[18] = mk(32'hABCDE897, 4'b0010, PCV,  32'hABCDE000, 5'd17, 1, 0, 0);
    tbl[19] = mk(32'h000000EF, 4'b0010, PCV,  32'd4,        5'd1,  1, 0, 0);
    tbl[20] = mk(32'h00008067, 4'b0010, PCV,  32'd4,        5'd0,  0, 0, 0);
    tbl[21] = mk(32'h0010D093, 4'b0000, 32'd0, 32'd0,       5'd1,  0, 0, 1);
    tbl[22] = mk(32'h0020B1B3, 4'b0000, 32'd0, 32'd0,       5'd3,  0, 0, 1);
    tbl[23] = mk(32'h0010B093, 4'b0000, 32'd0, 32'd0,       5'd1,  0, 0, 1);
    tbl[24] = mk(32'h0000007F, 4'b0000, 32'd0, 32'd0,       5'd0,  0, 0, 1);
    tbl[25] = mk(32'h40109093, 4'b0000, 32'd0, 32'd0,       5'd1,  0, 0, 1);

    v_add = mk(32'h002081B3, 4'b0010, 32'd5, 32'hFFFFFFF9, 5'd3, 1, 0, 0);
    v_sub = mk(32'h40208233, 4'b0011, RS1V, RS2V, 5'd4, 1, 0, 0);
    v_and = mk(32'h0020F2B3, 4'b0111, RS1V, RS2V, 5'd5, 1, 0, 0);
    v_sra = mk(32'h4020D1B3, 4'b0000, 32'd0, 32'd0, 5'd3, 0, 0, 1);
    v_lui = mk(32'h123453B7, 4'b0000, 32'd0, 32'h12345000, 5'd7, 1, 0, 0);

    // Reset held with a valid instruction on the input.
    rst_i = 1'b0;
    apply(v_add, 32'd5, 32'hFFFFFFF9);
    repeat (3) begin @(negedge clk_i); end
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
    chk("rst_src0", src0_o, 32'd0);
    chk("rst_src1", src1_o, 32'd0);
    chk("rst_rd", {27'd0, rd_o}, 32'd0);
    chk("rst_flags", {29'd0, reg_write_o, is_branch_o, illegal_o}, 32'd0);
    chk("rst_count", {16'd0, issue_count_o}, 32'd0);
    @(posedge clk_i); #1;
    idle();
    rst_i = 1'b1;
    at_neg();
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
    to_pos();

    // ADD x3,x1,x2 with rs1 = 5, rs2 = -7.
    apply(v_add, 32'd5, 32'hFFFFFFF9);
    wait_accept(cyc);
    idle();
    tick();
    tick();

    // Back-pressure: SUB held four cycles while AND waits.
    out_ready_i = 1'b0;
    apply(v_sub, RS1V, RS2V);
    wait_accept(cyc);
    apply(v_and, RS1V, RS2V);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("hold_valid", {31'd0, out_valid_o}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready_o}, 32'd0);
      chk("hold_ctrl", {28'd0, alu_ctrl_o}, 32'h3);
      chk("hold_src1", src1_o, RS2V);
      to_pos();
    end
    out_ready_i = 1'b1;
    wait_accept(cyc);
    chk("release_accept_cycles", cyc, 1);
    idle();
    tick();
    at_neg();
    chk("no_dup_valid", {31'd0, out_valid_o}, 32'd0);
    chk("bp_sb_empty", sb.size(), 0);
    to_pos();

    // Flush with slot full and a valid input present.
    out_ready_i = 1'b0;
    apply(v_add, RS1V, RS2V);
    cur.src0 = RS1V; cur.src1 = RS2V;
    wait_accept(cyc);
    apply(v_and, RS1V, RS2V);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    idle();
    if (sb.size() > 0) void'(sb.pop_front());
    at_neg();
    chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_ctrl", {28'd0, alu_ctrl_o}, 32'd0);
    chk("flush_count", {16'd0, issue_count_o}, {16'd0, exp_cnt});
    to_pos();
    out_ready_i = 1'b1;
    tick();

    // Reset while an op is held drops it.
    out_ready_i = 1'b0;
    apply(v_sub, RS1V, RS2V);
    wait_accept(cyc);
    idle();
    rst_i = 1'b0;
    #2;
    chk("midrst_valid", {31'd0, out_valid_o}, 32'd0);
    chk("midrst_count", {16'd0, issue_count_o}, 32'd0);
    reset_dut();

    // Eight back-to-back I-type ops.
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      apply(tbl[i], RS1V, RS2V);
      wait_accept(cyc);
      tot += cyc;
    end
    idle();
    tick();
    tick();
    chk("stream_cycles", tot, 8);
    chk("stream_count", {16'd0, issue_count_o}, 32'd8);
    chk("stream_sb_empty", sb.size(), 0);

    // Remaining vectors under random back-pressure.
    rand_bp = 1'b1;
    for (int i = 8; i < NVEC; i++) begin
      apply(tbl[i], RS1V, RS2V);
      wait_accept(cyc);
    end
    rand_bp = 1'b0;
    idle();
    out_ready_i = 1'b1;
    repeat (3) tick();
    chk("rand_sb_empty", sb.size(), 0);

    // SRA is illegal; the flag survives a following legal LUI.
    reset_dut();
    apply(v_sra, RS1V, RS2V);
    wait_accept(cyc);
    apply(v_lui, RS1V, RS2V);
    wait_accept(cyc);
    idle();
    tick();
    tick();
    chk("ill_sticky", {31'd0, illegal_o}, 32'd1);
    chk("ill_count", {16'd0, issue_count_o}, 32'd1);
    chk("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
